// File: rtl/gpu_raster_pkg.sv
// Shared raster-pipeline types: depth compare encodings, early-Z FSM states
// and default tile geometry.
package gpu_raster_pkg;

  localparam int DEF_COORD_W     = 16;
  localparam int DEF_DEPTH_W     = 16;
  localparam int DEF_TILE_X_BITS = 5;
  localparam int DEF_TILE_Y_BITS = 5;
  localparam int DEF_TAG_W       = 32;

  typedef enum logic [2:0] {
    DF_NEVER    = 3'd0,
    DF_LESS     = 3'd1,
    DF_EQUAL    = 3'd2,
    DF_LEQUAL   = 3'd3,
    DF_GREATER  = 3'd4,
    DF_NOTEQUAL = 3'd5,
    DF_GEQUAL   = 3'd6,
    DF_ALWAYS   = 3'd7
  } depth_func_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } edt_state_t;

endpackage

// File: rtl/depth_tile_ram.sv
// 1R1W depth tile memory with synchronous read; a read and write to the same
// address in one cycle returns the old contents.
module depth_tile_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage array and read register; read data holds while re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/early_depth_test.sv
// Early-Z stage: 3-stage depth test against an on-chip tile with tile clear.
// Optional depth-bounds kill enabled by defining DEPTH_BOUNDS_TEST_EN.
module early_depth_test
  import gpu_raster_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int DEPTH_W     = DEF_DEPTH_W,
  parameter int TILE_X_BITS = DEF_TILE_X_BITS,
  parameter int TILE_Y_BITS = DEF_TILE_Y_BITS,
  parameter int TAG_W       = DEF_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frag_in_valid,
  output logic               frag_in_ready,
  input  logic [COORD_W-1:0] frag_in_x,
  input  logic [COORD_W-1:0] frag_in_y,
  input  logic [DEPTH_W-1:0] frag_in_z,
  input  logic [TAG_W-1:0]   frag_in_tag,
  output logic               frag_out_valid,
  input  logic               frag_out_ready,
  output logic [COORD_W-1:0] frag_out_x,
  output logic [COORD_W-1:0] frag_out_y,
  output logic [DEPTH_W-1:0] frag_out_z,
  output logic [TAG_W-1:0]   frag_out_tag,
  input  logic [2:0]         cfg_depth_func,
  input  logic               cfg_depth_write,
`ifdef DEPTH_BOUNDS_TEST_EN
  input  logic [DEPTH_W-1:0] cfg_zmin,
  input  logic [DEPTH_W-1:0] cfg_zmax,
`endif
  input  logic               clear_req,
  input  logic [DEPTH_W-1:0] clear_value,
  output logic               clear_busy,
  output logic [31:0]        perf_frags_in,
  output logic [31:0]        perf_frags_passed,
  output logic [31:0]        perf_frags_killed
);

  localparam int AW = TILE_X_BITS + TILE_Y_BITS;
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic depth_pass(input depth_func_t f,
                                      input logic [DEPTH_W-1:0] z,
                                      input logic [DEPTH_W-1:0] s);
    logic r;
    r = 1'b0;
    case (f)
      DF_NEVER:    r = 1'b0;
      DF_LESS:     r = (z < s);
      DF_EQUAL:    r = (z == s);
      DF_LEQUAL:   r = (z <= s);
      DF_GREATER:  r = (z > s);
      DF_NOTEQUAL: r = (z != s);
      DF_GEQUAL:   r = (z >= s);
      DF_ALWAYS:   r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  edt_state_t state_q, state_d;
  logic [AW-1:0]      clr_addr_q, clr_addr_d;
  logic [DEPTH_W-1:0] clr_val_q, clr_val_d;
  logic               clear_busy_q, clear_busy_d;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_fresh_q, s1_fresh_d;
  logic [COORD_W-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [DEPTH_W-1:0] s1_z_q, s1_z_d, s1_hold_q, s1_hold_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [AW-1:0]      s1_addr_q, s1_addr_d;

  logic               s2_valid_q, s2_valid_d;
  logic [COORD_W-1:0] s2_x_q, s2_x_d, s2_y_q, s2_y_d;
  logic [DEPTH_W-1:0] s2_z_q, s2_z_d;
  logic [TAG_W-1:0]   s2_tag_q, s2_tag_d;

  logic               last_wr_valid_q, last_wr_valid_d;
  logic [AW-1:0]      last_wr_addr_q, last_wr_addr_d;
  logic [DEPTH_W-1:0] last_wr_data_q, last_wr_data_d;

  logic [31:0] cnt_in_q, cnt_in_d, cnt_pass_q, cnt_pass_d, cnt_kill_q, cnt_kill_d;

  logic [AW-1:0]      in_addr_s, ram_waddr_s;
  logic [DEPTH_W-1:0] ram_rdata_s, ram_wdata_s, stored_z_s;
  logic in_bounds_s, s1_pass_s, s2_free_s, s1_done_s, in_fire_s;
  logic s1_we_s, clr_we_s, ram_we_s;

  assign in_addr_s = {frag_in_y[TILE_Y_BITS-1:0], frag_in_x[TILE_X_BITS-1:0]};

`ifdef DEPTH_BOUNDS_TEST_EN
  assign in_bounds_s = (s1_z_q >= cfg_zmin) && (s1_z_q <= cfg_zmax);
`else
  assign in_bounds_s = 1'b1;
`endif

  // The RAM read misses a write made in the same cycle, so forward it on the
  // first S1 cycle; afterwards the resolved operand lives in s1_hold_q.
  always_comb begin
    stored_z_s = s1_hold_q;
    if (!s1_fresh_q) begin
      stored_z_s = s1_hold_q;
    end else if (last_wr_valid_q && (last_wr_addr_q == s1_addr_q)) begin
      stored_z_s = last_wr_data_q;
    end else begin
      stored_z_s = ram_rdata_s;
    end
  end

  assign s1_pass_s     = s1_valid_q && in_bounds_s &&
                         depth_pass(depth_func_t'(cfg_depth_func), s1_z_q, stored_z_s);
  assign s2_free_s     = !s2_valid_q || frag_out_ready;
  assign s1_done_s     = s1_valid_q && (!s1_pass_s || s2_free_s);
  assign frag_in_ready = (state_q == RUN) && (!s1_valid_q || s1_done_s);
  assign in_fire_s     = frag_in_valid && frag_in_ready;

  assign s1_we_s     = s1_pass_s && s2_free_s && cfg_depth_write;
  assign clr_we_s    = (state_q == CLEAR);
  assign ram_we_s    = clr_we_s || s1_we_s;
  assign ram_waddr_s = clr_we_s ? clr_addr_q : s1_addr_q;
  assign ram_wdata_s = clr_we_s ? clr_val_q : s1_z_q;

  depth_tile_ram #(
    .AW (AW),
    .DW (DEPTH_W)
  ) u_ram (
    .clk   (clk),
    .re    (in_fire_s),
    .raddr (in_addr_s),
    .rdata (ram_rdata_s),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s)
  );

  // Pipeline next-state for S1, S2 and the forwarding record.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_fresh_d = 1'b0;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_z_d     = s1_z_q;
    s1_tag_d   = s1_tag_q;
    s1_addr_d  = s1_addr_q;
    s1_hold_d  = stored_z_s;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_fresh_d = 1'b1;
      s1_x_d     = frag_in_x;
      s1_y_d     = frag_in_y;
      s1_z_d     = frag_in_z;
      s1_tag_d   = frag_in_tag;
      s1_addr_d  = in_addr_s;
    end else if (s1_done_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    s2_valid_d = s2_valid_q;
    s2_x_d     = s2_x_q;
    s2_y_d     = s2_y_q;
    s2_z_d     = s2_z_q;
    s2_tag_d   = s2_tag_q;
    if (s2_free_s) begin
      s2_valid_d = s1_pass_s;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
      s2_z_d     = s1_z_q;
      s2_tag_d   = s1_tag_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    last_wr_valid_d = ram_we_s;
    last_wr_addr_d  = ram_waddr_s;
    last_wr_data_d  = ram_wdata_s;
  end

  // Clear FSM: drain S1 so no fragment write races the sweep, then one address per cycle.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_val_d  = clr_val_q;
    case (state_q)
      RUN: begin
        if (clear_req) begin
          state_d    = DRAIN;
          clr_val_d  = clear_value;
          clr_addr_d = {AW{1'b0}};
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q) begin
          state_d = CLEAR;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_ONE;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      default: state_d = RUN;
    endcase
    clear_busy_d = (state_d != RUN);
  end

  // Performance counters.
  always_comb begin
    cnt_in_d   = cnt_in_q;
    cnt_pass_d = cnt_pass_q;
    cnt_kill_d = cnt_kill_q;
    if (in_fire_s) begin
      cnt_in_d = cnt_in_q + 32'd1;
    end else begin
      cnt_in_d = cnt_in_q;
    end
    if (s1_pass_s && s2_free_s) begin
      cnt_pass_d = cnt_pass_q + 32'd1;
    end else begin
      cnt_pass_d = cnt_pass_q;
    end
    if (s1_valid_q && !s1_pass_s) begin
      cnt_kill_d = cnt_kill_q + 32'd1;
    end else begin
      cnt_kill_d = cnt_kill_q;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      clr_addr_q      <= {AW{1'b0}};
      clear_busy_q    <= 1'b0;
      s1_valid_q      <= 1'b0;
      s1_fresh_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      last_wr_valid_q <= 1'b0;
      cnt_in_q        <= 32'd0;
      cnt_pass_q      <= 32'd0;
      cnt_kill_q      <= 32'd0;
    end else begin
      state_q         <= state_d;
      clr_addr_q      <= clr_addr_d;
      clear_busy_q    <= clear_busy_d;
      s1_valid_q      <= s1_valid_d;
      s1_fresh_q      <= s1_fresh_d;
      s2_valid_q      <= s2_valid_d;
      last_wr_valid_q <= last_wr_valid_d;
      cnt_in_q        <= cnt_in_d;
      cnt_pass_q      <= cnt_pass_d;
      cnt_kill_q      <= cnt_kill_d;
    end
  end

  // Datapath registers, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    clr_val_q      <= clr_val_d;
    s1_x_q         <= s1_x_d;
    s1_y_q         <= s1_y_d;
    s1_z_q         <= s1_z_d;
    s1_tag_q       <= s1_tag_d;
    s1_addr_q      <= s1_addr_d;
    s1_hold_q      <= s1_hold_d;
    s2_x_q         <= s2_x_d;
    s2_y_q         <= s2_y_d;
    s2_z_q         <= s2_z_d;
    s2_tag_q       <= s2_tag_d;
    last_wr_addr_q <= last_wr_addr_d;
    last_wr_data_q <= last_wr_data_d;
  end

  assign frag_out_valid    = s2_valid_q;
  assign frag_out_x        = s2_x_q;
  assign frag_out_y        = s2_y_q;
  assign frag_out_z        = s2_z_q;
  assign frag_out_tag      = s2_tag_q;
  assign clear_busy        = clear_busy_q;
  assign perf_frags_in     = cnt_in_q;
  assign perf_frags_passed = cnt_pass_q;
  assign perf_frags_killed = cnt_kill_q;

endmodule

// File: tb/tb_early_depth_test.sv
// Directed bench for early_depth_test: sequential depth model + output queue.
module tb_early_depth_test;

  logic        clk = 1'b0;
  logic        rst;
  logic        frag_in_valid, frag_in_ready;
  logic [15:0] frag_in_x, frag_in_y, frag_in_z;
  logic [31:0] frag_in_tag;
  logic        frag_out_valid, frag_out_ready;
  logic [15:0] frag_out_x, frag_out_y, frag_out_z;
  logic [31:0] frag_out_tag;
  logic [2:0]  cfg_depth_func;
  logic        cfg_depth_write;
  logic        clear_req;
  logic [15:0] clear_value;
  logic        clear_busy;
  logic [31:0] perf_frags_in, perf_frags_passed, perf_frags_killed;

  always #5 clk = ~clk;

  early_depth_test dut (
    .clk               (clk),
    .rst               (rst),
    .frag_in_valid     (frag_in_valid),
    .frag_in_ready     (frag_in_ready),
    .frag_in_x         (frag_in_x),
    .frag_in_y         (frag_in_y),
    .frag_in_z         (frag_in_z),
    .frag_in_tag       (frag_in_tag),
    .frag_out_valid    (frag_out_valid),
    .frag_out_ready    (frag_out_ready),
    .frag_out_x        (frag_out_x),
    .frag_out_y        (frag_out_y),
    .frag_out_z        (frag_out_z),
    .frag_out_tag      (frag_out_tag),
    .cfg_depth_func    (cfg_depth_func),
    .cfg_depth_write   (cfg_depth_write),
`ifdef DEPTH_BOUNDS_TEST_EN
    .cfg_zmin          (16'h0000),
    .cfg_zmax          (16'hFFFF),
`endif
    .clear_req         (clear_req),
    .clear_value       (clear_value),
    .clear_busy        (clear_busy),
    .perf_frags_in     (perf_frags_in),
    .perf_frags_passed (perf_frags_passed),
    .perf_frags_killed (perf_frags_killed)
  );

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [31:0] tag;
  } frag_t;

  int    total = 0;
  int    bad   = 0;
  logic [15:0] mmem [1024];
  frag_t expq[$];
  int    m_in, m_pass, m_kill;
  bit    saw_stall;
  bit    prev_hold;
  frag_t prev_f;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit ref_pass(input int f, input int z, input int s);
    case (f)
      0: return 1'b0;
      1: return z < s;
      2: return z == s;
      3: return z <= s;
      4: return z > s;
      5: return z != s;
      6: return z >= s;
      default: return 1'b1;
    endcase
  endfunction

  // Model: fragments resolve in acceptance order against a plain array.
  initial begin
    frag_t cur;
    int a;
    forever begin
      @(negedge clk);
      cur = {frag_out_x, frag_out_y, frag_out_z, frag_out_tag};
      if (rst) begin
        expq.delete();
        m_in = 0; m_pass = 0; m_kill = 0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("out_stable", {frag_out_valid, cur}, {1'b1, prev_f});
        prev_hold = frag_out_valid && !frag_out_ready;
        prev_f    = cur;
        if (frag_out_valid && frag_out_ready) begin
          if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL out_unexpected: got %0h want no output", cur);
          end else begin
            chk("out_frag", cur, expq.pop_front());
          end
        end
        if (clear_busy && frag_in_valid) chk("ready_in_clear", frag_in_ready, 1'b0);
        if (frag_in_valid && !frag_in_ready) saw_stall = 1'b1;
        if (frag_in_valid && frag_in_ready) begin
          a = int'(frag_in_y[4:0]) * 32 + int'(frag_in_x[4:0]);
          m_in++;
          if (ref_pass(int'(cfg_depth_func), int'(frag_in_z), int'(mmem[a]))) begin
            expq.push_back({frag_in_x, frag_in_y, frag_in_z, frag_in_tag});
            if (cfg_depth_write) mmem[a] = frag_in_z;
            m_pass++;
          end else begin
            m_kill++;
          end
        end
        if (clear_req) begin
          for (int i = 0; i < 1024; i++) mmem[i] = clear_value;
        end
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [31:0] tag);
    bit got;
    got = 1'b0;
    frag_in_valid = 1'b1;
    frag_in_x = x; frag_in_y = y; frag_in_z = z; frag_in_tag = tag;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = frag_in_ready;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_timeout: got ready=0 want ready=1 tag %0h", tag);
    end
    @(posedge clk); #1;
    frag_in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear(input logic [15:0] v);
    clear_value = v;
    clear_req   = 1'b1;
    @(posedge clk); #1;
    clear_req   = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    @(negedge clk);
    while (clear_busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL clear_timeout: got busy for %0d cycles want done", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input int cin, input int cpass, input int ckill);
    chk("perf_in",    perf_frags_in,     cin);
    chk("perf_pass",  perf_frags_passed, cpass);
    chk("perf_kill",  perf_frags_killed, ckill);
    chk("model_in",   m_in,   cin);
    chk("model_pass", m_pass, cpass);
    chk("model_kill", m_kill, ckill);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; frag_in_valid = 1'b0;
    frag_in_x = 16'd0; frag_in_y = 16'd0; frag_in_z = 16'd0; frag_in_tag = 32'd0;
    frag_out_ready = 1'b1; cfg_depth_func = 3'd1; cfg_depth_write = 1'b1;
    clear_req = 1'b0; clear_value = 16'd0; saw_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {frag_out_valid, clear_busy, frag_in_ready}, 3'b001);
    chk("rst_counters", {perf_frags_in, perf_frags_passed, perf_frags_killed}, 96'd0);
    @(posedge clk); #1;
    pulse_clear(16'hFFFF);
    wait_clear(n);

    // 1: latency and a killed repeat
    send(16'd3, 16'd4, 16'h1000, 32'h0000_00A1);
    @(negedge clk);
    chk("lat_n1_valid", frag_out_valid, 1'b0);
    @(negedge clk);
    chk("lat_n2_frag", {frag_out_valid, frag_out_x, frag_out_y, frag_out_z, frag_out_tag},
        {1'b1, 16'd3, 16'd4, 16'h1000, 32'h0000_00A1});
    @(posedge clk); #1;
    send(16'd3, 16'd4, 16'h2000, 32'h0000_00A2);
    settle(4);
    check_counts(2, 1, 1);

    // 2: back-to-back same pixel
    send(16'd5, 16'd6, 16'h0800, 32'h0000_00B1);
    send(16'd5, 16'd6, 16'h0700, 32'h0000_00B2);
    send(16'd5, 16'd6, 16'h0750, 32'h0000_00B3);
    settle(4);
    check_counts(5, 3, 2);

    // 3: output stall with three passing fragments (first two alias one pixel)
    frag_out_ready = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        send(16'd40, 16'd1,  16'h3000, 32'h0000_00C1);
        send(16'd8,  16'd33, 16'h2000, 32'h0000_00C2);
        send(16'd7,  16'd7,  16'h0100, 32'h0000_00C3);
      end
      begin
        repeat (6) @(posedge clk);
        #1 frag_out_ready = 1'b1;
      end
    join
    settle(4);
    chk("in_ready_dropped", saw_stall, 1'b1);
    check_counts(8, 6, 2);
    send(16'd8, 16'd1, 16'h2500, 32'h0000_00C4);
    settle(4);
    check_counts(9, 6, 3);

    // 4: clear mid-traffic, then GEQUAL against 0x8000
    cfg_depth_func = 3'd6;
    clear_value = 16'h8000;
    clear_req = 1'b1;
    send(16'd10, 16'd10, 16'h0100, 32'h0000_00D1);
    clear_req = 1'b0;
    fork
      wait_clear(n);
      begin
        send(16'd12, 16'd3, 16'h8000, 32'h0000_00D2);
        send(16'd12, 16'd4, 16'h7FFF, 32'h0000_00D3);
      end
    join
    settle(4);
    chk("clear_busy_len", (n >= 1025 && n <= 1028), 1'b1);
    check_counts(12, 7, 5);

    // 5: ALWAYS without write leaves memory alone; NEVER emits nothing
    pulse_clear(16'hFFFF);
    wait_clear(n);
    cfg_depth_func = 3'd7; cfg_depth_write = 1'b0;
    send(16'd1, 16'd1, 16'h0010, 32'h0000_00E1);
    send(16'd1, 16'd1, 16'h0020, 32'h0000_00E2);
    settle(4);
    cfg_depth_func = 3'd1; cfg_depth_write = 1'b1;
    send(16'd1, 16'd1, 16'hFFFE, 32'h0000_00E3);
    settle(4);
    check_counts(15, 10, 5);
    cfg_depth_func = 3'd0;
    send(16'd2, 16'd2, 16'h0000, 32'h0000_00E4);
    send(16'd3, 16'd3, 16'h0005, 32'h0000_00E5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("never_no_out", frag_out_valid, 1'b0);
    end
    @(posedge clk); #1;
    check_counts(17, 10, 7);

    // 6: reset in the middle of a clear with a stuck output
    cfg_depth_func = 3'd1;
    frag_out_ready = 1'b0;
    send(16'd20, 16'd20, 16'h0010, 32'h0000_00F1);
    settle(3);
    pulse_clear(16'h1234);
    settle(50);
    @(negedge clk);
    chk("busy_before_rst", {clear_busy, frag_out_valid}, 2'b11);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_clear", {clear_busy, frag_out_valid, frag_in_ready}, 3'b001);
    chk("rst_mid_counters", {perf_frags_in, perf_frags_passed, perf_frags_killed}, 96'd0);
    @(posedge clk); #1;
    frag_out_ready = 1'b1;
    settle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
